// File: rtl/snake_controller_gen.sv
// snake_controller_gen: game/direction/execution FSMs plus row-multiplexed LED matrix scan.
// Optional SNAKE_STOP_BLINK_EN blanks the matrix on alternate ticks while the game is stopped.
module snake_controller_gen #(
  parameter int unsigned ROWS            = 8,
  parameter int unsigned COLS            = 8,
  parameter int unsigned SCAN_CYCLES     = 1024,
  parameter int unsigned FRAMES_PER_TICK = 16
) (
  input  logic                 clka,
  input  logic                 restart,
  input  logic [3:0]           direction_in,
  input  logic                 logic_done,
  input  logic                 need_prng,
  input  logic                 game_over,
  input  logic                 prng_done,
  input  logic [ROWS*COLS-1:0] led_array,
  output logic [1:0]           game_state,
  output logic [1:0]           direction_state,
  output logic [2:0]           execution_state,
  output logic                 logic_start,
  output logic                 prng_req,
  output logic [ROWS-1:0]      row_cathode,
  output logic [COLS-1:0]      column_anode,
  output logic                 tick
);
  localparam int unsigned SCAN_W  = $clog2(SCAN_CYCLES + 1);
  localparam int unsigned ROW_W   = $clog2(ROWS);
  localparam int unsigned FRAME_W = $clog2(FRAMES_PER_TICK + 1);

  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_CYCLES - 1);
  localparam logic [ROW_W-1:0]   ROW_LAST   = ROW_W'(ROWS - 1);
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(FRAMES_PER_TICK - 1);

  localparam logic [1:0] INIT = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] STOP = 2'd2;

  localparam logic [1:0] UP    = 2'd0;
  localparam logic [1:0] DOWN  = 2'd1;
  localparam logic [1:0] LEFT  = 2'd2;
  localparam logic [1:0] RIGHT = 2'd3;

  localparam logic [2:0] CHECK_STATE  = 3'd0;
  localparam logic [2:0] INPUT        = 3'd1;
  localparam logic [2:0] WAIT_LOGIC   = 3'd2;
  localparam logic [2:0] UPDATE_STATE = 3'd3;
  localparam logic [2:0] REQUEST_PRNG = 3'd4;
  localparam logic [2:0] WAIT_PRNG    = 3'd5;
  localparam logic [2:0] DISPLAY      = 3'd6;

  logic               pend_valid, pend_valid_nxt;
  logic [1:0]         pend_dir, pend_dir_nxt;
  logic               cap_prng, cap_prng_nxt;
  logic               cap_over, cap_over_nxt;
  logic [SCAN_W-1:0]  scan_cnt, scan_nxt;
  logic [ROW_W-1:0]   row_cnt, row_nxt;
  logic [FRAME_W-1:0] frame_cnt, frame_nxt;
  logic [1:0]         game_nxt, dir_nxt;
  logic [2:0]         exec_nxt;
  logic               logic_start_nxt, prng_req_nxt, tick_nxt;
  logic [ROWS-1:0]    row_cathode_nxt;
  logic [COLS-1:0]    column_anode_nxt;
  logic               btn_valid;
  logic [1:0]         btn_dir;
  logic               enter_display;
  logic               blank;
  logic               pend_rev;

`ifdef SNAKE_STOP_BLINK_EN
  logic blink, blink_nxt;
`endif

  // UP/DOWN and LEFT/RIGHT share bit 1 and differ only in bit 0
  assign pend_rev = (pend_dir[1] == direction_state[1]) && (pend_dir[0] != direction_state[0]);

  always_comb begin
    pend_valid_nxt   = pend_valid;
    pend_dir_nxt     = pend_dir;
    cap_prng_nxt     = cap_prng;
    cap_over_nxt     = cap_over;
    scan_nxt         = scan_cnt;
    row_nxt          = row_cnt;
    frame_nxt        = frame_cnt;
    game_nxt         = game_state;
    dir_nxt          = direction_state;
    exec_nxt         = execution_state;
    logic_start_nxt  = 1'b0;
    prng_req_nxt     = 1'b0;
    tick_nxt         = 1'b0;
    row_cathode_nxt  = '1;
    column_anode_nxt = '0;
    btn_valid        = 1'b0;
    btn_dir          = UP;
    enter_display    = 1'b0;
    blank            = 1'b0;

    // Only an exactly one-hot press is latched; the latest one wins
    case (direction_in)
      4'b0001: begin btn_valid = 1'b1; btn_dir = UP;    end
      4'b0010: begin btn_valid = 1'b1; btn_dir = DOWN;  end
      4'b0100: begin btn_valid = 1'b1; btn_dir = LEFT;  end
      4'b1000: begin btn_valid = 1'b1; btn_dir = RIGHT; end
      default: ;
    endcase
    if (btn_valid) begin
      pend_valid_nxt = 1'b1;
      pend_dir_nxt   = btn_dir;
    end

    case (execution_state)
      CHECK_STATE: begin
        if (game_state == RUN || (game_state == INIT && pend_valid)) begin
          exec_nxt        = INPUT;
          game_nxt        = RUN;
          logic_start_nxt = 1'b1;
          if (pend_valid) begin
            if (!pend_rev) dir_nxt = pend_dir;
            if (!btn_valid) pend_valid_nxt = 1'b0;
          end
        end else begin
          enter_display = 1'b1;
        end
      end
      INPUT: exec_nxt = WAIT_LOGIC;
      WAIT_LOGIC: begin
        if (logic_done) begin
          cap_prng_nxt = need_prng;
          cap_over_nxt = game_over;
          exec_nxt     = UPDATE_STATE;
        end
      end
      UPDATE_STATE: begin
        if (cap_over) begin
          game_nxt      = STOP;
          enter_display = 1'b1;
        end else if (cap_prng) begin
          exec_nxt     = REQUEST_PRNG;
          prng_req_nxt = 1'b1;
        end else begin
          enter_display = 1'b1;
        end
      end
      REQUEST_PRNG: exec_nxt = WAIT_PRNG;
      WAIT_PRNG: if (prng_done) enter_display = 1'b1;
      DISPLAY: begin
        if (scan_cnt == SCAN_LAST) begin
          scan_nxt = '0;
          if (row_cnt == ROW_LAST) begin
            row_nxt = '0;
            if (frame_cnt == FRAME_LAST) begin
              frame_nxt = '0;
              exec_nxt  = CHECK_STATE;
              tick_nxt  = 1'b1;
            end else begin
              frame_nxt = frame_cnt + 1'b1;
            end
          end else begin
            row_nxt = row_cnt + 1'b1;
          end
        end else begin
          scan_nxt = scan_cnt + 1'b1;
        end
      end
      default: exec_nxt = CHECK_STATE;
    endcase

    if (enter_display) begin
      exec_nxt  = DISPLAY;
      scan_nxt  = '0;
      row_nxt   = '0;
      frame_nxt = '0;
    end

`ifdef SNAKE_STOP_BLINK_EN
    blink_nxt = blink ^ (tick_nxt && game_state == STOP);
    blank     = (game_nxt == STOP) && !blink;
`endif

    // Row drive is registered, so it follows the counter values for the next cycle
    if (exec_nxt == DISPLAY) begin
      row_cathode_nxt  = ~(ROWS'(1) << row_nxt);
      column_anode_nxt = blank ? '0 : led_array[32'(row_nxt) * COLS +: COLS];
    end
  end

  always_ff @(posedge clka or posedge restart) begin
    if (restart) begin
      game_state      <= INIT;
      direction_state <= RIGHT;
      execution_state <= CHECK_STATE;
      logic_start     <= 1'b0;
      prng_req        <= 1'b0;
      tick            <= 1'b0;
      row_cathode     <= '1;
      column_anode    <= '0;
      pend_valid      <= 1'b0;
      pend_dir        <= UP;
      cap_prng        <= 1'b0;
      cap_over        <= 1'b0;
      scan_cnt        <= '0;
      row_cnt         <= '0;
      frame_cnt       <= '0;
    end else begin
      game_state      <= game_nxt;
      direction_state <= dir_nxt;
      execution_state <= exec_nxt;
      logic_start     <= logic_start_nxt;
      prng_req        <= prng_req_nxt;
      tick            <= tick_nxt;
      row_cathode     <= row_cathode_nxt;
      column_anode    <= column_anode_nxt;
      pend_valid      <= pend_valid_nxt;
      pend_dir        <= pend_dir_nxt;
      cap_prng        <= cap_prng_nxt;
      cap_over        <= cap_over_nxt;
      scan_cnt        <= scan_nxt;
      row_cnt         <= row_nxt;
      frame_cnt       <= frame_nxt;
    end
  end

`ifdef SNAKE_STOP_BLINK_EN
  always_ff @(posedge clka or posedge restart) begin
    if (restart) blink <= 1'b0;
    else         blink <= blink_nxt;
  end
`endif

endmodule
